// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - shared access-direction codes and FSM state encoding for data_mem_bridge
package data_mem_bridge_pkg;

  // Access direction as carried by mem_rw_in; the bus write-enable follows MEM_WRITE.
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Bridge states; encodings kept identical to the legacy defines.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - req/ack data-memory bus between the MEM-stage bridge and data memory
interface data_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [3:0]            bus_sel;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_error;

  modport master (
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_error,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_error,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - MEM-stage bus master: one req/ack transaction per access; optional timeout under DMEM_TIMEOUT_EN
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  pipe_stall,
  input  logic                  mem_enable_in,
  input  logic                  mem_rw_in,
  input  logic [3:0]            mem_sel_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] mem_read_out,
  data_mem_bridge_if.master     bus
);

  // Word alignment: the bus only ever sees word addresses.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("data_mem_bridge: TIMEOUT_CYCLES must be within 1..255");
  end

  dmem_state_e state;
  logic        drop;
  logic        drop_now;

  // A flush arriving in the same cycle as the ack squashes that access too.
  assign drop_now = drop | flush;

  // Hold the pipeline while an access is being launched or is in flight.
  assign stall_req = ((state == DMEM_IDLE) & mem_enable_in & ~flush) | (state == DMEM_REQ);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       bus_error_q;
  assign bus.bus_error = bus_error_q;
`else
  assign bus.bus_error = 1'b0;
`endif

  // Bridge FSM with registered bus outputs and latched read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= DMEM_IDLE;
      drop          <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_sel   <= 4'b0000;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      mem_read_out  <= '0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt      <= 8'd0;
      bus_error_q   <= 1'b0;
`endif
    end else begin
`ifdef DMEM_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
      case (state)
        DMEM_IDLE: begin
          if (mem_enable_in && !flush) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= (mem_rw_in == MEM_WRITE);
            bus.bus_sel   <= mem_sel_in;
            bus.bus_addr  <= addr_in & WORD_MASK;
            bus.bus_wdata <= wdata_in;
            drop          <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt      <= 8'd0;
`endif
            state         <= DMEM_REQ;
          end
        end

        DMEM_REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (bus.bus_we == MEM_READ && !drop_now)
              mem_read_out <= bus.bus_rdata;
            drop  <= 1'b0;
            state <= drop_now ? DMEM_IDLE : DMEM_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            bus.bus_req <= 1'b0;
            bus_error_q <= 1'b1;
            if (bus.bus_we == MEM_READ && !drop_now)
              mem_read_out <= '0;
            drop  <= 1'b0;
            state <= drop_now ? DMEM_IDLE : DMEM_DONE;
          end
`endif
          else begin
            if (flush)
              drop <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        DMEM_DONE: begin
          if (flush || !pipe_stall)
            state <= DMEM_IDLE;
        end

        default: state <= DMEM_IDLE;
      endcase
    end
  end

endmodule
